// File: rtl/wb_stage.sv
// Writeback stage: selects the result source, aligns load data, and waits for late loads.
// It drives the register-file write port one cycle after commit.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_wb_sel,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic [XLEN-1:0] i_csr_rdata,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_reg_write,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    input  logic            i_flush,
    output logic            o_rd_we,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_busy,
    output logic            o_misalign,
    output logic            o_timeout
);
    localparam int OW = $clog2(XLEN / 8);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic {StIdle, StWaitMem} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wait_cnt;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [2:0]      r_addr_lo;
    logic            r_reg_write;
    logic            r_rd_we;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_data;
    logic            r_misalign;
    logic            r_timeout;

    logic            w_idle;
    logic            w_accept;
    logic            w_is_mem;
    logic [2:0]      w_f3;
    logic [2:0]      w_addr_lo;
    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_load_data;
    logic            w_load_mis;
    logic [XLEN-1:0] w_src_data;
    logic            w_tmo_hit;
    logic            w_commit;
    logic            w_c_rw;
    logic [4:0]      w_c_rd;
    logic [XLEN-1:0] w_c_data;
    logic            w_c_mis;
    logic            w_c_we;

    assign w_idle    = (r_state == StIdle);
    assign w_accept  = i_valid && w_idle && !i_flush;
    assign w_is_mem  = (i_wb_sel == 2'b01);
    // A same-cycle load uses the live request fields; a late load uses the captured ones.
    assign w_f3      = w_idle ? i_funct3 : r_funct3;
    assign w_addr_lo = w_idle ? i_alu_result[2:0] : r_addr_lo;
    assign w_shift   = i_dmem_rdata >> {w_addr_lo[OW-1:0], 3'b000};
    assign w_tmo_hit = (TIMEOUT > 0) && (r_wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_load_data = XLEN'($signed(w_shift[31:0]));
        w_load_mis  = (w_addr_lo[1:0] != 2'b00);
        unique case (w_f3)
            3'b000: begin
                w_load_data = XLEN'($signed(w_shift[7:0]));
                w_load_mis  = 1'b0;
            end
            3'b001: begin
                w_load_data = XLEN'($signed(w_shift[15:0]));
                w_load_mis  = w_addr_lo[0];
            end
            3'b100: begin
                w_load_data = XLEN'(w_shift[7:0]);
                w_load_mis  = 1'b0;
            end
            3'b101: begin
                w_load_data = XLEN'(w_shift[15:0]);
                w_load_mis  = w_addr_lo[0];
            end
            3'b110: w_load_data = XLEN'(w_shift[31:0]);
            3'b011: begin
                if (XLEN == 64) begin
                    w_load_data = w_shift;
                    w_load_mis  = (w_addr_lo != 3'b000);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_src_data = i_alu_result;
        unique case (i_wb_sel)
            2'b10:   w_src_data = i_pc_plus4;
            2'b11:   w_src_data = i_csr_rdata;
            default: w_src_data = i_alu_result;
        endcase
    end

    always_comb begin
        w_commit = 1'b0;
        w_c_rw   = i_reg_write;
        w_c_rd   = i_rd_addr;
        w_c_data = w_src_data;
        w_c_mis  = 1'b0;
        if (w_accept) begin
            if (!w_is_mem) begin
                w_commit = 1'b1;
            end else if (i_dmem_rvalid) begin
                w_commit = 1'b1;
                w_c_data = w_load_data;
                w_c_mis  = w_load_mis;
            end
        end else if (!w_idle && !i_flush && i_dmem_rvalid) begin
            w_commit = 1'b1;
            w_c_rw   = r_reg_write;
            w_c_rd   = r_rd;
            w_c_data = w_load_data;
            w_c_mis  = w_load_mis;
        end
        w_c_we = w_commit && w_c_rw && (w_c_rd != 5'd0) && !w_c_mis;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_rd        <= '0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_reg_write <= 1'b0;
            r_rd_we     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_rd_we    <= w_c_we;
            r_misalign <= w_commit && w_c_mis;
            r_timeout  <= 1'b0;
            // Write port holds its last committed value when no write happens.
            if (w_c_we) begin
                r_rd_addr <= w_c_rd;
                r_rd_data <= w_c_data;
            end
            case (r_state)
                StIdle: begin
                    if (w_accept && w_is_mem && !i_dmem_rvalid) begin
                        r_state     <= StWaitMem;
                        r_wait_cnt  <= '0;
                        r_rd        <= i_rd_addr;
                        r_funct3    <= i_funct3;
                        r_addr_lo   <= i_alu_result[2:0];
                        r_reg_write <= i_reg_write;
                    end
                end
                StWaitMem: begin
                    if (i_flush || i_dmem_rvalid) begin
                        r_state <= StIdle;
                    end else if (w_tmo_hit) begin
                        r_state   <= StIdle;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ready    = w_idle;
    assign o_busy     = (r_state == StWaitMem);
    assign o_rd_we    = r_rd_we;
    assign o_rd_addr  = r_rd_addr;
    assign o_rd_data  = r_rd_data;
    assign o_misalign = r_misalign;
    assign o_timeout  = r_timeout;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 32-bit instance with a short timeout and a 64-bit instance.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  sel;
    logic [63:0] alu;
    logic [63:0] pc4;
    logic [63:0] csr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic        rvalid;
    logic [63:0] rdata;
    logic        flush;

    logic        a_ready, a_we, a_busy, a_mis, a_tmo;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_ready, b_we, b_busy, b_mis, b_tmo;
    logic [4:0]  b_rd;
    logic [63:0] b_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .TIMEOUT(4)) u_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(a_ready), .i_wb_sel(sel),
        .i_alu_result(alu[31:0]), .i_pc_plus4(pc4[31:0]), .i_csr_rdata(csr[31:0]),
        .i_funct3(f3), .i_rd_addr(rd), .i_reg_write(rw), .i_dmem_rvalid(rvalid),
        .i_dmem_rdata(rdata[31:0]), .i_flush(flush), .o_rd_we(a_we), .o_rd_addr(a_rd),
        .o_rd_data(a_data), .o_busy(a_busy), .o_misalign(a_mis), .o_timeout(a_tmo)
    );

    wb_stage #(.XLEN(64)) u_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(b_ready), .i_wb_sel(sel),
        .i_alu_result(alu), .i_pc_plus4(pc4), .i_csr_rdata(csr),
        .i_funct3(f3), .i_rd_addr(rd), .i_reg_write(rw), .i_dmem_rvalid(rvalid),
        .i_dmem_rdata(rdata), .i_flush(flush), .o_rd_we(b_we), .o_rd_addr(b_rd),
        .o_rd_data(b_data), .o_busy(b_busy), .o_misalign(b_mis), .o_timeout(b_tmo)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [63:0] alu;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic        rvalid;
        logic [63:0] rdata;
        logic        flush;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_mis;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid = 1'b0; sel = 2'b00; alu = '0; f3 = 3'b000; rd = 5'd0; rw = 1'b0;
        rvalid = 1'b0; rdata = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_we"}, a_we, 0);
        chk({tag, "_rd"}, a_rd, 0);
        chk({tag, "_data"}, a_data, 0);
        chk({tag, "_mis"}, a_mis, 0);
        chk({tag, "_tmo"}, a_tmo, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_ready"}, a_ready, 1);
    endtask

    task automatic mem_req(input logic [63:0] addr, input logic [2:0] fn, input logic [4:0] r,
                           input logic rv, input logic [63:0] rd_word);
        valid = 1'b1; sel = 2'b01; alu = addr; f3 = fn; rd = r; rw = 1'b1;
        rvalid = rv; rdata = rd_word; flush = 1'b0;
    endtask

    initial begin
        pc4 = 64'h0000_1004;
        csr = 64'hCAFE_0001;
        //            valid sel   alu                f3    rd  rw rv rdata              fl we rd  data           mis
        vecs[0]  = '{1, 2'd0, 64'h1234,         3'd0, 5,  1, 0, 64'h0,             0, 1, 5,  32'h0000_1234, 0};
        vecs[1]  = '{1, 2'd2, 64'h0,            3'd0, 7,  1, 0, 64'h0,             0, 1, 7,  32'h0000_1004, 0};
        vecs[2]  = '{1, 2'd3, 64'h0,            3'd0, 8,  1, 0, 64'h0,             0, 1, 8,  32'hCAFE_0001, 0};
        vecs[3]  = '{0, 2'd0, 64'h77,           3'd0, 9,  1, 0, 64'h0,             0, 0, 8,  32'hCAFE_0001, 0};
        vecs[4]  = '{1, 2'd0, 64'h55,           3'd0, 0,  1, 0, 64'h0,             0, 0, 8,  32'hCAFE_0001, 0};
        vecs[5]  = '{1, 2'd0, 64'h66,           3'd0, 9,  0, 0, 64'h0,             0, 0, 8,  32'hCAFE_0001, 0};
        vecs[6]  = '{1, 2'd1, 64'h1,            3'd0, 10, 1, 1, 64'h0000_8000,     0, 1, 10, 32'hFFFF_FF80, 0};
        vecs[7]  = '{1, 2'd1, 64'h2,            3'd4, 11, 1, 1, 64'h00AB_0000,     0, 1, 11, 32'h0000_00AB, 0};
        vecs[8]  = '{1, 2'd1, 64'h2,            3'd1, 12, 1, 1, 64'h8001_0000,     0, 1, 12, 32'hFFFF_8001, 0};
        vecs[9]  = '{1, 2'd1, 64'h2,            3'd5, 13, 1, 1, 64'h8001_0000,     0, 1, 13, 32'h0000_8001, 0};
        vecs[10] = '{1, 2'd1, 64'h0,            3'd2, 14, 1, 1, 64'hDEAD_BEEF,     0, 1, 14, 32'hDEAD_BEEF, 0};
        vecs[11] = '{1, 2'd1, 64'h2,            3'd2, 3,  1, 1, 64'h1111_2222,     0, 0, 14, 32'hDEAD_BEEF, 1};
        vecs[12] = '{1, 2'd1, 64'h1,            3'd1, 3,  1, 1, 64'h1111_2222,     0, 0, 14, 32'hDEAD_BEEF, 1};
        vecs[13] = '{1, 2'd1, 64'h0,            3'd7, 15, 1, 1, 64'h1234_5678,     0, 1, 15, 32'h1234_5678, 0};
        vecs[14] = '{1, 2'd0, 64'h99,           3'd0, 16, 1, 0, 64'h0,             1, 0, 15, 32'h1234_5678, 0};
        vecs[15] = '{1, 2'd1, 64'h0,            3'd3, 17, 1, 1, 64'h8765_4321,     0, 1, 17, 32'h8765_4321, 0};

        // Reset state, then the first cycle after release.
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        chk_a_zero("reset");
        chk("reset_b_data", b_data, 0);
        rst = 1'b0;
        step();
        chk("post_reset_ready", a_ready, 1);

        for (int i = 0; i < 16; i++) begin
            valid = vecs[i].valid; sel = vecs[i].sel; alu = vecs[i].alu; f3 = vecs[i].f3;
            rd = vecs[i].rd; rw = vecs[i].rw; rvalid = vecs[i].rvalid;
            rdata = vecs[i].rdata; flush = vecs[i].flush;
            step();
            chk($sformatf("vec%0d_we", i), a_we, vecs[i].e_we);
            chk($sformatf("vec%0d_rd", i), a_rd, vecs[i].e_rd);
            chk($sformatf("vec%0d_data", i), a_data, vecs[i].e_data);
            chk($sformatf("vec%0d_mis", i), a_mis, vecs[i].e_mis);
            chk($sformatf("vec%0d_busy", i), a_busy, 0);
        end

        // Delayed LB: three busy cycles, then sign-extended byte 3.
        mem_req(64'h3, 3'd0, 5'd20, 1'b0, 64'h0);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lb_wait%0d_busy", i), a_busy, 1);
            chk($sformatf("lb_wait%0d_ready", i), a_ready, 0);
            chk($sformatf("lb_wait%0d_we", i), a_we, 0);
            if (i == 2) begin
                rvalid = 1'b1;
                rdata  = 64'h80FF_FFFF;
            end
            step();
        end
        rvalid = 1'b0;
        chk("lb_late_we", a_we, 1);
        chk("lb_late_rd", a_rd, 20);
        chk("lb_late_data", a_data, 32'hFFFF_FF80);
        chk("lb_late_busy", a_busy, 0);

        // Flush in WAIT_MEM wins over a simultaneous rvalid.
        mem_req(64'h0, 3'd2, 5'd21, 1'b0, 64'h0);
        step();
        idle_inputs();
        chk("flush_busy", a_busy, 1);
        flush = 1'b1; rvalid = 1'b1; rdata = 64'h5555_5555;
        step();
        idle_inputs();
        chk("flush_we", a_we, 0);
        chk("flush_ready", a_ready, 1);
        chk("flush_hold_rd", a_rd, 20);
        step();
        chk("flush_after_we", a_we, 0);

        // Timeout after four wait cycles.
        mem_req(64'h0, 3'd2, 5'd22, 1'b0, 64'h0);
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_wait%0d_busy", i), a_busy, 1);
            chk($sformatf("tmo_wait%0d_pulse", i), a_tmo, 0);
            step();
        end
        chk("tmo_pulse", a_tmo, 1);
        chk("tmo_we", a_we, 0);
        chk("tmo_busy", a_busy, 0);
        step();
        chk("tmo_pulse_end", a_tmo, 0);
        chk("tmo_ready", a_ready, 1);

        // Reset abandons a pending load.
        mem_req(64'h0, 3'd2, 5'd23, 1'b0, 64'h0);
        step();
        idle_inputs();
        chk("rstmid_busy", a_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_a_zero("rstmid");
        rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        idle_inputs();
        chk_a_zero("rstmid_after");
        chk("rstmid_b_we", b_we, 0);

        // 64-bit loads.
        mem_req(64'h4, 3'd6, 5'd24, 1'b1, 64'hDEAD_BEEF_0000_0000);
        step();
        chk("lwu64_we", b_we, 1);
        chk("lwu64_rd", b_rd, 24);
        chk("lwu64_data", b_data, 64'h0000_0000_DEAD_BEEF);
        mem_req(64'h4, 3'd2, 5'd25, 1'b1, 64'hDEAD_BEEF_0000_0000);
        step();
        chk("lw64_data", b_data, 64'hFFFF_FFFF_DEAD_BEEF);
        mem_req(64'h0, 3'd3, 5'd26, 1'b1, 64'h8000_0000_0000_0001);
        step();
        chk("ld64_data", b_data, 64'h8000_0000_0000_0001);
        mem_req(64'h4, 3'd3, 5'd27, 1'b1, 64'h1);
        step();
        chk("ld64_mis", b_mis, 1);
        chk("ld64_mis_we", b_we, 0);
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles spent in WAIT_MEM; 0 disables the timeout.
REQ-003 SHALL have ports (name  direction  width  meaning):
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  upstream writeback request valid.
- o_ready  out  1  stage can accept a request.
- i_wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 CSR.
- i_alu_result  in  XLEN  ALU result; also the load address for MEM.
- i_pc_plus4  in  XLEN  return address.
- i_csr_rdata  in  XLEN  CSR read value.
- i_funct3  in  3  load size/sign.
- i_rd_addr  in  5  destination register.
- i_reg_write  in  1  request carries a register write.
- i_dmem_rvalid  in  1  load data valid.
- i_dmem_rdata  in  XLEN  raw memory word.
- i_flush  in  1  kill the pending or incoming request.
- o_rd_we  out  1  register-file write strobe.
- o_rd_addr  out  5  write address.
- o_rd_data  out  XLEN  write data.
- o_busy  out  1  state is WAIT_MEM.
- o_misalign  out  1  one-cycle pulse, misaligned load.
- o_timeout  out  1  one-cycle pulse, load timed out.

Function
REQ-004 SHALL implement states IDLE and WAIT_MEM; o_ready = (state==IDLE).
REQ-005 SHALL accept a request when i_valid && o_ready && !i_flush; i_flush in the same cycle drops it with no output effect.
REQ-006 SHALL register its outputs at one-cycle latency: for an accepted non-MEM request, o_rd_we/o_rd_addr/o_rd_data are valid on the cycle after acceptance.
REQ-007 SHALL, for an accepted MEM request with i_dmem_rvalid high in the same cycle, commit the aligned data on the next cycle and remain in IDLE.
REQ-008 SHALL, for an accepted MEM request with i_dmem_rvalid low, capture rd_addr, funct3, address low bits and reg_write, then move to WAIT_MEM.
REQ-009 SHALL, in WAIT_MEM with i_dmem_rvalid high, commit the aligned data on the next cycle and return to IDLE.
REQ-010 SHALL, in WAIT_MEM with i_flush high, return to IDLE with no write; i_flush takes priority over i_dmem_rvalid in the same cycle.
REQ-011 SHALL, in WAIT_MEM, count waiting cycles; when the count reaches TIMEOUT (TIMEOUT>0), pulse o_timeout, write nothing, and return to IDLE.
REQ-012 SHALL align load data as follows:
- byte offset = address[log2(XLEN/8)-1:0].
- funct3 000 LB: sign-extend the byte at the offset.
- 001 LH: sign-extend the halfword.
- 010 LW: sign-extend the word (zero-fill irrelevant at XLEN=32).
- 100 LBU, 101 LHU, 110 LWU: zero-extend.
- 011 LD: full word, XLEN=64 only.
- Undefined funct3 codes yield LW behaviour.
REQ-013 SHALL treat an access as misaligned when LH/LHU address[0]!=0, LW/LWU address[1:0]!=0, or LD address[2:0]!=0.
REQ-014 SHALL, on a misaligned access, pulse o_misalign on the commit cycle and suppress the write.
REQ-015 SHALL drive o_rd_we = reg_write && rd_addr!=0 && !misalign on the commit cycle, low otherwise.
REQ-016 SHALL hold o_rd_addr/o_rd_data at their last committed values while o_rd_we is low.
REQ-017 SHALL update o_rd_we, o_misalign and o_timeout every cycle as single-cycle pulses.

Reset
REQ-018 SHALL, with i_rst high at a clock edge, set state=IDLE, clear the wait counter, and drive o_rd_we=0, o_rd_addr=0, o_rd_data=0, o_misalign=0, o_timeout=0, o_busy=0.
REQ-019 SHALL abandon a load pending when reset asserts, with no write after reset releases.
REQ-020 SHALL hold o_ready=1 in the first cycle after reset release.

Verification
REQ-021 ALU path: sel=00, alu=0x0000_1234, rd=5, reg_write=1 -> next cycle o_rd_we=1, rd=5, data=0x0000_1234.
REQ-022 Delayed LB: sel=01, addr=0x...03, funct3=000; rvalid arrives 3 cycles later with rdata=0x80FF_FFFF -> o_busy high 3 cycles, then data=0xFFFF_FF80, rd_we=1.
REQ-023 Misalign plus x0: LW at addr 0x...02 -> o_misalign pulse, rd_we=0; ALU write with rd=0 -> rd_we=0, no pulse.
REQ-024 Flush/timeout: i_flush during WAIT_MEM -> IDLE, no write; TIMEOUT=4 with no rvalid -> o_timeout pulses after 4 wait cycles, o_ready=1 next cycle.
REQ-025 Reset mid-load: i_rst asserted in WAIT_MEM, then rvalid after release -> no write, all outputs 0.
REQ-026 XLEN=64 LWU: addr offset 4, rdata=0xDEAD_BEEF_0000_0000 -> data=0x0000_0000_DEAD_BEEF.
